// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS load/store stage:
// memory opcodes, FSM state type and opcode classification helpers.
package mips_cpu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } ls_state_t;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_mem_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU,
            OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Unaligned lwl/lwr and byte accesses are legal by definition.
    function automatic logic is_misaligned(input logic [5:0] op,
                                           input logic [1:0] b);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = b[0];
            OP_LW, OP_SW:         bad = (b != 2'b00);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Load data formatter: selects, extends or merges bus read data
// into the writeback value according to opcode and byte offset.
module mips_cpu_load_align
    import mips_cpu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [1:0]  b,
    input  logic [31:0] m,
    input  logic [31:0] rt,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = m[7:0];
        case (b)
            2'd0: byte_sel = m[7:0];
            2'd1: byte_sel = m[15:8];
            2'd2: byte_sel = m[23:16];
            2'd3: byte_sel = m[31:24];
            default: byte_sel = m[7:0];
        endcase
        half_sel = b[1] ? m[31:16] : m[15:0];
    end

    always_comb begin
        rdata = m;
        case (opcode)
            OP_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: rdata = {24'd0, byte_sel};
            OP_LH:  rdata = {{16{half_sel[15]}}, half_sel};
            OP_LHU: rdata = {16'd0, half_sel};
            OP_LW:  rdata = m;
            OP_LWL: begin
                case (b)
                    2'd0: rdata = {m[7:0], rt[23:0]};
                    2'd1: rdata = {m[15:0], rt[15:0]};
                    2'd2: rdata = {m[23:0], rt[7:0]};
                    default: rdata = m;
                endcase
            end
            OP_LWR: begin
                case (b)
                    2'd0: rdata = m;
                    2'd1: rdata = {rt[31:24], m[31:8]};
                    2'd2: rdata = {rt[31:16], m[31:16]};
                    default: rdata = {rt[31:8], m[31:24]};
                endcase
            end
            default: rdata = m;
        endcase
    end

endmodule

// File: rtl/mips_cpu_load_store.sv
// Memory-access stage: one Avalon-MM transaction per load/store with
// alignment checking, optional wait timeout and load formatting.
module mips_cpu_load_store
    import mips_cpu_pkg::*;
#(
    parameter int MAX_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] rt_content,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        addr_error,
    output logic        timeout,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [31:0] WAIT_LIM =
        (MAX_WAIT > 0) ? 32'(MAX_WAIT - 1) : 32'd0;

    ls_state_t   state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  b_q, b_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] aligned;

    mips_cpu_load_align u_align (
        .opcode (op_q),
        .b      (b_q),
        .m      (avm_readdata),
        .rt     (rt_q),
        .rdata  (aligned)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        b_d       = b_q;
        rt_d      = rt_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        address_d = address_q;
        read_d    = read_q;
        write_d   = write_q;
        be_d      = be_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (start && is_mem_op(opcode)) begin
                    op_d   = opcode;
                    b_d    = addr[1:0];
                    rt_d   = rt_content;
                    wait_d = 32'd0;
                    err_d  = 1'b0;
                    tmo_d  = 1'b0;
                    if (is_misaligned(opcode, addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d   = ACCESS;
                        address_d = {addr[31:2], 2'b00};
                        read_d    = !is_store(opcode);
                        write_d   = is_store(opcode);
                        case (opcode)
                            OP_SB: begin
                                be_d    = 4'b0001 << addr[1:0];
                                wdata_d = {4{rt_content[7:0]}};
                            end
                            OP_SH: begin
                                be_d    = addr[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{rt_content[15:0]}};
                            end
                            OP_SW: begin
                                be_d    = 4'b1111;
                                wdata_d = rt_content;
                            end
                            default: be_d = 4'b1111;
                        endcase
                    end
                end
            end
            ACCESS: begin
                if (!avm_waitrequest) begin
                    if (read_q) rdata_d = aligned;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = DONE;
                end else if ((MAX_WAIT > 0) && (wait_q == WAIT_LIM)) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 32'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= 6'd0;
            b_q       <= 2'd0;
            rt_q      <= 32'd0;
            wait_q    <= 32'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            address_q <= 32'd0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            b_q       <= b_d;
            rt_q      <= rt_d;
            wait_q    <= wait_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            tmo_q     <= tmo_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign rdata_out      = rdata_q;
    assign addr_error     = err_q;
    assign timeout        = tmo_q;
    assign avm_address    = address_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_byteenable = be_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_mips_cpu_load_store.sv
// Scoreboard bench for mips_cpu_load_store: randomized loads/stores
// against an arithmetic reference model, with a wait-state bus slave.
module tb_mips_cpu_load_store;
    import mips_cpu_pkg::*;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_content = 32'd0;
    logic        busy, done, addr_error, timeout;
    logic [31:0] rdata_out, avm_address, avm_writedata;
    logic        avm_read, avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_waitrequest = 1'b0;

    mips_cpu_load_store #(.MAX_WAIT(MW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .opcode          (opcode),
        .addr            (addr),
        .rt_content      (rt_content),
        .busy            (busy),
        .done            (done),
        .rdata_out       (rdata_out),
        .addr_error      (addr_error),
        .timeout         (timeout),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] address;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        err;
        logic        tmo;
        logic [31:0] rdata;
        int          strobes;
        int          done_cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          cur_wait = 0;
    logic [31:0] cur_rdata = 32'd0;
    logic [31:0] last_rdata = 32'd0;
    logic [5:0]  ops[10] = '{OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU,
                             OP_LHU, OP_LWR, OP_SB, OP_SH, OP_SW};

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [5:0] op,
        input logic [1:0] b, input logic [31:0] m, input logic [31:0] rt);
        int          sh;
        logic [31:0] byt, half;
        sh   = 8 * int'(b);
        byt  = (m >> sh) & 32'hFF;
        half = (m >> (16 * int'(b[1]))) & 32'hFFFF;
        case (op)
            OP_LB:  return byt[7] ? (byt | 32'hFFFFFF00) : byt;
            OP_LBU: return byt;
            OP_LH:  return half[15] ? (half | 32'hFFFF0000) : half;
            OP_LHU: return half;
            OP_LWL: return (m << (24 - sh)) | (rt & (32'hFFFFFFFF >> (sh + 8)));
            OP_LWR: return (m >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
            default: return m;
        endcase
    endfunction

    // Bus slave: stalls the first cur_wait strobe cycles, junk data meanwhile.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (avm_read || avm_write) begin
                if (wcnt < cur_wait) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom;
                    wcnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = cur_rdata;
                end
            end else begin
                wcnt            = 0;
                avm_waitrequest = 1'($urandom_range(0, 1));
                avm_readdata    = $urandom;
            end
        end
    end

    // Monitor: checks bus beats against the queue head and pops on done.
    initial begin
        int   scnt;
        exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                scnt = 0;
                continue;
            end
            if (avm_read || avm_write) begin
                if (q.size() == 0) begin
                    chk("bus_unexpected", 32'(avm_read | avm_write), 32'd0);
                end else begin
                    e = q[0];
                    chk("avm_read", 32'(avm_read), 32'(e.rd));
                    chk("avm_write", 32'(avm_write), 32'(e.wr));
                    chk("avm_address", avm_address, e.address);
                    chk("avm_byteenable", 32'(avm_byteenable), 32'(e.be));
                    if (e.wr) chk("avm_writedata", avm_writedata, e.wdata);
                end
                scnt++;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("addr_error", 32'(addr_error), 32'(e.err));
                    chk("timeout", 32'(timeout), 32'(e.tmo));
                    chk("rdata_out", rdata_out, e.rdata);
                    chk("strobe_cycles", 32'(scnt), 32'(e.strobes));
                    chk("done_latency", 32'(cyc), 32'(e.done_cyc));
                end
                scnt = 0;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 with the DUT idle.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] rt, input logic [31:0] m,
                         input int w, input bit noise);
        exp_t       e;
        logic [1:0] b;
        bit         ld;
        int         n;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_wait_expired", 32'(busy), 32'd0);
        b    = a[1:0];
        ld   = !(op == OP_SB || op == OP_SH || op == OP_SW);
        e.rd = ld;
        e.wr = !ld;
        e.address = {a[31:2], 2'b00};
        e.be      = 4'b1111;
        e.wdata   = rt;
        if (op == OP_SB) begin
            e.be    = 4'(1 << b);
            e.wdata = 32'(rt[7:0]) * 32'h01010101;
        end
        if (op == OP_SH) begin
            e.be    = 4'(3 << b);
            e.wdata = 32'(rt[15:0]) * 32'h00010001;
        end
        e.err = ((op == OP_LH || op == OP_LHU || op == OP_SH) && b[0]) ||
                ((op == OP_LW || op == OP_SW) && b != 2'b00);
        e.tmo = !e.err && (w >= MW);
        e.strobes = e.err ? 0 : ((w >= MW) ? MW : w + 1);
        if (ld && !e.err && !e.tmo) last_rdata = ref_load(op, b, m, rt);
        e.rdata    = last_rdata;
        e.done_cyc = cyc + 1 + e.strobes;
        q.push_back(e);
        cur_wait   = w;
        cur_rdata  = m;
        start      = 1'b1;
        opcode     = op;
        addr       = a;
        rt_content = rt;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            start      = (noise && busy) ? 1'b1 : 1'b0;
            opcode     = ops[$urandom_range(0, 9)];
            addr       = $urandom;
            rt_content = $urandom;
        end while (busy && n < 50);
        start = 1'b0;
        if (busy) chk("done_wait_expired", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("reset_ctrl", 32'({busy, done, addr_error, timeout, avm_read,
                               avm_write, avm_byteenable}), 32'd0);
        chk("reset_rdata", rdata_out, 32'd0);
        chk("reset_address", avm_address, 32'd0);
        chk("reset_wdata", avm_writedata, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op(OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0, 0);
        do_op(OP_LB,  32'h203, 32'h0,        32'h80112233, 0, 0);
        do_op(OP_LBU, 32'h203, 32'h0,        32'h80112233, 1, 1);
        do_op(OP_SH,  32'h302, 32'h0000ABCD, 32'h0,        3, 0);
        do_op(OP_LWL, 32'h401, 32'h11223344, 32'hAABBCCDD, 0, 0);
        do_op(OP_LWR, 32'h401, 32'h11223344, 32'hAABBCCDD, 2, 1);
        do_op(OP_LW,  32'h102, 32'h0,        32'h12345678, 0, 0);
        do_op(OP_LW,  32'h104, 32'h0,        32'h12345678, 6, 0);
        do_op(OP_SB,  32'h501, 32'h000000A5, 32'h0,        0, 1);

        // Non-memory opcode must not start a transaction.
        start  = 1'b1;
        opcode = 6'h00;
        addr   = 32'h600;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("nonmem_busy", 32'(busy), 32'd0);
        chk("nonmem_strobe", 32'(avm_read | avm_write), 32'd0);

        // Reset in the middle of a stalled read.
        begin
            exp_t e;
            e.rd = 1'b1; e.wr = 1'b0; e.address = 32'h700; e.be = 4'hF;
            e.wdata = 32'd0; e.err = 1'b0; e.tmo = 1'b0; e.rdata = 32'd0;
            e.strobes = 0; e.done_cyc = 0;
            q.push_back(e);
        end
        cur_wait = 10;
        start    = 1'b1;
        opcode   = OP_LW;
        addr     = 32'h700;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("pre_reset_read", 32'(avm_read), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midreset_read", 32'(avm_read), 32'd0);
        chk("midreset_ctrl", 32'({busy, done, addr_error, timeout,
                                  avm_write, avm_byteenable}), 32'd0);
        chk("midreset_rdata", rdata_out, 32'd0);
        chk("midreset_address", avm_address, 32'd0);
        q.delete();
        last_rdata = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [5:0] op;
            int         w;
            op = ops[$urandom_range(0, 9)];
            w  = ($urandom_range(0, 9) == 0) ? $urandom_range(MW, MW + 2)
                                              : $urandom_range(0, MW - 1);
            do_op(op, $urandom, $urandom, $urandom, w,
                  1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
